// File: rtl/mod_mult_barrett_pipe.sv
// Pipelined Barrett modular multiplier: oData = (iData0*iData1) mod iMod, with
// the modulus, bit length, Barrett constant and tag carried alongside every operation.
module mod_mult_barrett_pipe #(
    parameter int W       = 64,
    parameter int MUL_LAT = 4,
    parameter int TAG_W   = 8
) (
    input  logic                 iClk,
    input  logic                 iRstN,
    input  logic                 iEn,
    input  logic                 iClr,
    input  logic                 iValid,
    input  logic [W-1:0]         iData0,
    input  logic [W-1:0]         iData1,
    input  logic [W-1:0]         iMod,
    input  logic [$clog2(W):0]   iK,
    input  logic [W:0]           iU,
    input  logic [TAG_W-1:0]     iTag,
    output logic                 oValid,
    output logic [W-1:0]         oData,
    output logic [TAG_W-1:0]     oTag
);

    localparam int KW = $clog2(W) + 1;
    localparam int N  = MUL_LAT;
    localparam int S  = 3 * MUL_LAT;

    logic [2*W-1:0]   zPipe   [S];
    logic [W-1:0]     qPipe   [S];
    logic [TAG_W-1:0] tagPipe [S];
    logic [KW-1:0]    kPipe   [2*N];
    logic [W:0]       uPipe   [N];
    logic [2*W+1:0]   m2Pipe  [N];
    logic [W+1:0]     pPipe   [N];
    logic [S-1:0]     vld;

    logic [2*W-1:0]   zIn;
    logic [KW-1:0]    sh1;
    logic [KW-1:0]    sh2;
    logic [W:0]       m1;
    logic [2*W+1:0]   m2In;
    logic [W:0]       m3;
    logic [W+1:0]     pIn;
    logic [W+1:0]     t;
    logic [W+1:0]     qx;
    logic [W+1:0]     q2;
    logic [W-1:0]     res;

    // Each multiplier forms its product at the head of its segment; the following
    // MUL_LAT registers are left for retiming to spread the multiplier across.
    assign zIn  = {{W{1'b0}}, iData0} * {{W{1'b0}}, iData1};
    assign sh1  = kPipe[N-1] - KW'(1);
    assign m1   = (W+1)'(zPipe[N-1] >> sh1);
    assign m2In = {{(W+1){1'b0}}, m1} * {{(W+1){1'b0}}, uPipe[N-1]};
    assign sh2  = kPipe[2*N-1] + KW'(1);
    assign m3   = (W+1)'(m2Pipe[N-1] >> sh2);
    assign pIn  = (W+2)'(m3) * (W+2)'(qPipe[2*N-1]);

    // Only W+2 bits of the remainder matter: the Barrett estimate is within 2q of z.
    assign t  = zPipe[S-1][W+1:0] - pPipe[N-1];
    assign qx = {2'b00, qPipe[S-1]};
    assign q2 = {1'b0, qPipe[S-1], 1'b0};

    always_comb begin
        res = W'(t);
        if (t >= q2) begin
            res = W'(t - q2);
        end else if (t >= qx) begin
            res = W'(t - qx);
        end
    end

    // Data path registers need no reset; their validity is tracked separately.
    always_ff @(posedge iClk) begin
        if (iEn) begin
            zPipe[0]   <= zIn;
            qPipe[0]   <= iMod;
            tagPipe[0] <= iTag;
            kPipe[0]   <= iK;
            uPipe[0]   <= iU;
            m2Pipe[0]  <= m2In;
            pPipe[0]   <= pIn;
            for (int i = 1; i < S; i++) begin
                zPipe[i]   <= zPipe[i-1];
                qPipe[i]   <= qPipe[i-1];
                tagPipe[i] <= tagPipe[i-1];
            end
            for (int i = 1; i < 2*N; i++) begin
                kPipe[i] <= kPipe[i-1];
            end
            for (int i = 1; i < N; i++) begin
                uPipe[i]  <= uPipe[i-1];
                m2Pipe[i] <= m2Pipe[i-1];
                pPipe[i]  <= pPipe[i-1];
            end
        end
    end

    // Output data and tag only update for valid results, so bubbles never disturb them.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            vld    <= '0;
            oValid <= 1'b0;
            oData  <= '0;
            oTag   <= '0;
        end else if (iClr) begin
            vld    <= '0;
            oValid <= 1'b0;
            oData  <= '0;
            oTag   <= '0;
        end else if (iEn) begin
            vld    <= {vld[S-2:0], iValid};
            oValid <= vld[S-1];
            if (vld[S-1]) begin
                oData <= res;
                oTag  <= tagPipe[S-1];
            end
        end
    end

endmodule

// File: tb/tb_mod_mult_barrett_pipe.sv
// Self-checking bench for mod_mult_barrett_pipe: random and directed operations are
// scored against a plain (a*b) mod q model with per-operation enabled-cycle timing.
module tb_mod_mult_barrett_pipe;

    localparam int L = 13;

    logic        iClk = 1'b0;
    logic        iRstN = 1'b0;
    logic        iEn = 1'b0;
    logic        iClr = 1'b0;
    logic        iValid = 1'b0;
    logic [63:0] iData0 = '0;
    logic [63:0] iData1 = '0;
    logic [63:0] iMod = '0;
    logic [6:0]  iK = '0;
    logic [64:0] iU = '0;
    logic [7:0]  iTag = '0;
    logic        oValid;
    logic [63:0] oData;
    logic [7:0]  oTag;

    int checks = 0;
    int fails  = 0;

    logic [63:0] opA, opB, opQ;
    logic [6:0]  opK;
    logic [64:0] opU;
    logic [7:0]  opTag;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  t;
        int          due;
    } expEntryT;

    expEntryT    pend[$];
    int          enCnt  = 0;
    logic        expV   = 1'b0;
    logic [63:0] expD   = '0;
    logic [7:0]  expT   = '0;
    logic        zeroed = 1'b1;

    mod_mult_barrett_pipe #(.W(64), .MUL_LAT(4), .TAG_W(8)) dut (
        .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iValid(iValid),
        .iData0(iData0), .iData1(iData1), .iMod(iMod), .iK(iK), .iU(iU),
        .iTag(iTag), .oValid(oValid), .oData(oData), .oTag(oTag)
    );

    always #5 iClk = ~iClk;

    function automatic logic [63:0] modelMul(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] q);
        logic [127:0] p;
        p = {64'b0, a} * {64'b0, b};
        return 64'(p % {64'b0, q});
    endfunction

    function automatic logic [64:0] barrettU(input logic [63:0] q, input int k);
        logic [135:0] num;
        num = 136'd1 << (2 * k);
        return 65'(num / {72'b0, q});
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic en, input logic clr);
        @(posedge iClk);
        #1;
        iValid = valid;
        iEn    = en;
        iClr   = clr;
        iData0 = opA;
        iData1 = opB;
        iMod   = opQ;
        iK     = opK;
        iU     = opU;
        iTag   = opTag;
    endtask

    task automatic genOp();
        logic [135:0] tmp;
        int k;
        k   = $urandom_range(2, 64);
        tmp = {72'b0, $urandom, $urandom};
        tmp = tmp & ((136'd1 << k) - 136'd1);
        tmp = tmp | (136'd1 << (k - 1));
        opQ = tmp[63:0];
        opK = 7'(k);
        opU = barrettU(opQ, k);
        opA = {$urandom, $urandom} % opQ;
        opB = {$urandom, $urandom} % opQ;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    task automatic streamOps(input int n, input bit stall);
        logic en;
        for (int i = 0; i < n; i++) begin
            genOp();
            opTag = 8'(i);
            do begin
                en = stall ? ($urandom_range(0, 4) < 3) : 1'b1;
                applyStimulus(1'b1, en, 1'b0);
            end while (!en);
        end
    endtask

    task automatic runDirected(input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] q, input logic [6:0] k,
                               input logic [64:0] u, input logic [7:0] tag,
                               input logic [63:0] wantData, input string name);
        int cyc;
        opA = a; opB = b; opQ = q; opK = k; opU = u; opTag = tag;
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        cyc = 0;
        while (cyc <= 40) begin
            @(negedge iClk);
            cyc++;
            if (oValid) break;
        end
        checkOutput({name, " latency"}, 64'(cyc), 64'(L));
        checkOutput({name, " data"}, oData, wantData);
        checkOutput({name, " tag"}, 64'(oTag), 64'(tag));
    endtask

    // Reference timing: a result is due L-1 enabled edges after the edge that sampled it.
    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN || iClr) begin
            pend.delete();
            expV   = 1'b0;
            expD   = '0;
            expT   = '0;
            zeroed = 1'b1;
        end else if (iEn) begin
            enCnt++;
            if (iValid) begin
                pend.push_back('{d: modelMul(iData0, iData1, iMod), t: iTag, due: enCnt + L - 1});
            end
            if (pend.size() > 0 && pend[0].due == enCnt) begin
                expV   = 1'b1;
                expD   = pend[0].d;
                expT   = pend[0].t;
                zeroed = 1'b0;
                void'(pend.pop_front());
            end else begin
                expV = 1'b0;
            end
        end
    end

    always @(negedge iClk) begin
        checkOutput("oValid", 64'(oValid), 64'(expV));
        if (expV || zeroed) begin
            checkOutput("oData", oData, expD);
            checkOutput("oTag", 64'(oTag), 64'(expT));
        end
    end

    initial begin
        logic [63:0] q61;
        opA = '0; opB = '0; opQ = 64'd13; opK = 7'd4; opU = 65'd19; opTag = '0;
        repeat (3) @(posedge iClk);
        #3 iRstN = 1'b1;
        idle(2);

        runDirected(64'd7, 64'd11, 64'd13, 7'd4, 65'd19, 8'd5, 64'd12, "small");

        q61 = 64'h1FFF_FFFF_FFFF_FFFF;
        runDirected(q61 - 64'd1, q61 - 64'd1, q61, 7'd61, barrettU(q61, 61), 8'hA1, 64'd1, "mersenne");
        runDirected(64'd0, q61 - 64'd1, q61, 7'd61, barrettU(q61, 61), 8'hA2, 64'd0, "zero");

        streamOps(1000, 1'b0);
        idle(L + 3);
        checkOutput("stream drained", 64'(pend.size()), 64'd0);

        streamOps(20, 1'b1);
        idle(L + 3);
        checkOutput("stall drained", 64'(pend.size()), 64'd0);

        streamOps(5, 1'b0);
        genOp();
        applyStimulus(1'b1, 1'b0, 1'b1);
        idle(L + 3);
        runDirected(64'd7, 64'd11, 64'd13, 7'd4, 65'd19, 8'd9, 64'd12, "after clear");

        streamOps(20, 1'b0);
        @(posedge iClk);
        #3 iRstN = 1'b0;
        iValid = 1'b0;
        #1;
        checkOutput("async reset oValid", 64'(oValid), 64'd0);
        checkOutput("async reset oData", oData, 64'd0);
        checkOutput("async reset oTag", 64'(oTag), 64'd0);
        @(posedge iClk);
        #3 iRstN = 1'b1;
        idle(L + 3);
        runDirected(64'd3, 64'd5, 64'd13, 7'd4, 65'd19, 8'd77, 64'd2, "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
